// File: rtl/pipeline_pkg.sv
// Shared widths, control-bit positions and forward-select codes for the ID/EX slice.
// Forward precompute is enabled by defining ID_EX_FWD_PRECOMPUTE_EN.
package pipeline_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;
  localparam int CTRL_W = 9;

  localparam int CTRL_REGDST   = 8;
  localparam int CTRL_ALUSRC   = 7;
  localparam int CTRL_ALUOP_HI = 6;
  localparam int CTRL_ALUOP_LO = 4;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic [DATA_W-1:0] imm;
  } id_ex_t;

  function automatic logic [REG_W-1:0] destOf(
    input logic             regDst,
    input logic [REG_W-1:0] rt,
    input logic [REG_W-1:0] rd
  );
    return regDst ? rd : rt;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-to-EX bundle: decode-side inputs, registered EX-side outputs, hazard flags.
// Forward selects stay 00 unless ID_EX_FWD_PRECOMPUTE_EN is defined.
interface id_ex_stage_if;
  import pipeline_pkg::*;

  logic              Stall;
  logic              Flush;
  logic [CTRL_W-1:0] ID_Ctrl;
  logic [REG_W-1:0]  ID_Rs;
  logic [REG_W-1:0]  ID_Rt;
  logic [REG_W-1:0]  ID_Rd;
  logic [DATA_W-1:0] ID_ReadData1;
  logic [DATA_W-1:0] ID_ReadData2;
  logic [DATA_W-1:0] ID_Imm;

  logic [CTRL_W-1:0] EX_Ctrl;
  logic [REG_W-1:0]  EX_Rs;
  logic [REG_W-1:0]  EX_Rt;
  logic [REG_W-1:0]  EX_Rd;
  logic [DATA_W-1:0] EX_ReadData1;
  logic [DATA_W-1:0] EX_ReadData2;
  logic [DATA_W-1:0] EX_Imm;
  logic              EX_Valid;
  logic              LoadStall;
  logic [1:0]        EX_ForwardA;
  logic [1:0]        EX_ForwardB;

  modport master (
    output Stall, Flush, ID_Ctrl, ID_Rs, ID_Rt, ID_Rd,
    output ID_ReadData1, ID_ReadData2, ID_Imm,
    input  EX_Ctrl, EX_Rs, EX_Rt, EX_Rd,
    input  EX_ReadData1, EX_ReadData2, EX_Imm,
    input  EX_Valid, LoadStall, EX_ForwardA, EX_ForwardB
  );

  modport slave (
    input  Stall, Flush, ID_Ctrl, ID_Rs, ID_Rt, ID_Rd,
    input  ID_ReadData1, ID_ReadData2, ID_Imm,
    output EX_Ctrl, EX_Rs, EX_Rt, EX_Rd,
    output EX_ReadData1, EX_ReadData2, EX_Imm,
    output EX_Valid, LoadStall, EX_ForwardA, EX_ForwardB
  );

endinterface

// File: rtl/id_ex_hazard.sv
// Load-use detection against the EX slot and, with ID_EX_FWD_PRECOMPUTE_EN,
// next-cycle forward selects from the P1/P2 shadow state.
module id_ex_hazard
  import pipeline_pkg::*;
(
  input  logic             exValid,
  input  logic             exRegDst,
  input  logic             exMemRead,
  input  logic             exRegWrite,
  input  logic [REG_W-1:0] exRt,
  input  logic [REG_W-1:0] exRd,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  output logic             loadStall
`ifdef ID_EX_FWD_PRECOMPUTE_EN
  ,
  input  logic [REG_W-1:0] p1Dest,
  input  logic             p1Wr,
  input  logic             p1Valid,
  input  logic [REG_W-1:0] p2Dest,
  input  logic             p2Wr,
  input  logic             p2Valid,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB
`endif
);

  logic [REG_W-1:0] exDest;

  assign exDest = destOf(exRegDst, exRt, exRd);

  assign loadStall = exValid & exMemRead & exRegWrite
                   & (exDest != '0)
                   & ((exDest == idRs) | (exDest == idRt));

`ifdef ID_EX_FWD_PRECOMPUTE_EN
  // P1 is the nearer producer, so it is tested first
  function automatic logic [1:0] fwdSel(input logic [REG_W-1:0] src);
    if (p1Valid && p1Wr && p1Dest != '0 && p1Dest == src)
      return FWD_MEM;
    else if (p2Valid && p2Wr && p2Dest != '0 && p2Dest == src)
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

  assign fwdA = fwdSel(idRs);
  assign fwdB = fwdSel(idRt);
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion, stall hold and load-use detect.
// ID_EX_FWD_PRECOMPUTE_EN adds P1/P2 shadow state and registered forward selects.
module id_ex_stage
  import pipeline_pkg::*;
(
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  id_ex_t     idBundle;
  id_ex_t     exBundle;
  logic       exValid;
  logic       loadStall;
  logic       bubble;
  logic [1:0] fwdA;
  logic [1:0] fwdB;

  assign idBundle = '{
    ctrl:      bus.ID_Ctrl,
    rs:        bus.ID_Rs,
    rt:        bus.ID_Rt,
    rd:        bus.ID_Rd,
    readData1: bus.ID_ReadData1,
    readData2: bus.ID_ReadData2,
    imm:       bus.ID_Imm
  };

  assign bubble = bus.Flush | loadStall;

  always_ff @(posedge clk) begin
    if (rst) begin
      exBundle <= '0;
      exValid  <= 1'b0;
    end else if (bubble) begin
      exBundle      <= idBundle;
      exBundle.ctrl <= '0;
      exValid       <= 1'b0;
    end else if (!bus.Stall) begin
      exBundle <= idBundle;
      exValid  <= 1'b1;
    end
  end

`ifdef ID_EX_FWD_PRECOMPUTE_EN
  logic [REG_W-1:0] p1Dest;
  logic [REG_W-1:0] p2Dest;
  logic             p1Wr;
  logic             p2Wr;
  logic             p1Valid;
  logic             p2Valid;
  logic [1:0]       fwdANext;
  logic [1:0]       fwdBNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      p1Dest  <= '0;
      p1Wr    <= 1'b0;
      p1Valid <= 1'b0;
      p2Dest  <= '0;
      p2Wr    <= 1'b0;
      p2Valid <= 1'b0;
      fwdA    <= FWD_REG;
      fwdB    <= FWD_REG;
    end else if (bubble || !bus.Stall) begin
      p2Dest  <= p1Dest;
      p2Wr    <= p1Wr;
      p2Valid <= p1Valid;
      p1Dest  <= destOf(bus.ID_Ctrl[CTRL_REGDST], bus.ID_Rt, bus.ID_Rd);
      p1Wr    <= !bubble && bus.ID_Ctrl[CTRL_REGWRITE];
      p1Valid <= !bubble;
      fwdA    <= bubble ? FWD_REG : fwdANext;
      fwdB    <= bubble ? FWD_REG : fwdBNext;
    end
  end
`else
  assign fwdA = FWD_REG;
  assign fwdB = FWD_REG;
`endif

  id_ex_hazard uHazard (
    .exValid    (exValid),
    .exRegDst   (exBundle.ctrl[CTRL_REGDST]),
    .exMemRead  (exBundle.ctrl[CTRL_MEMREAD]),
    .exRegWrite (exBundle.ctrl[CTRL_REGWRITE]),
    .exRt       (exBundle.rt),
    .exRd       (exBundle.rd),
    .idRs       (bus.ID_Rs),
    .idRt       (bus.ID_Rt),
    .loadStall  (loadStall)
`ifdef ID_EX_FWD_PRECOMPUTE_EN
    ,
    .p1Dest     (p1Dest),
    .p1Wr       (p1Wr),
    .p1Valid    (p1Valid),
    .p2Dest     (p2Dest),
    .p2Wr       (p2Wr),
    .p2Valid    (p2Valid),
    .fwdA       (fwdANext),
    .fwdB       (fwdBNext)
`endif
  );

  assign bus.EX_Ctrl      = exBundle.ctrl;
  assign bus.EX_Rs        = exBundle.rs;
  assign bus.EX_Rt        = exBundle.rt;
  assign bus.EX_Rd        = exBundle.rd;
  assign bus.EX_ReadData1 = exBundle.readData1;
  assign bus.EX_ReadData2 = exBundle.readData2;
  assign bus.EX_Imm       = exBundle.imm;
  assign bus.EX_Valid     = exValid;
  assign bus.LoadStall    = loadStall;
  assign bus.EX_ForwardA  = fwdA;
  assign bus.EX_ForwardB  = fwdB;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed plus random bench for id_ex_stage against a queue-based pipeline model.
// Forward expectations follow ID_EX_FWD_PRECOMPUTE_EN.
module tb_id_ex_stage;
  import pipeline_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [8:0]  ctrl;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [15:0] imm;
    logic [1:0]  fa;
    logic [1:0]  fb;
  } rec_t;

  // pipe[0] is the instruction in EX, pipe[1] the one that left EX before it
  rec_t pipe[$];

  localparam logic [8:0] C_WR   = 9'h002;
  localparam logic [8:0] C_ADD  = 9'h122;
  localparam logic [8:0] C_LOAD = 9'h08B;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] recDest(input rec_t r);
    return r.ctrl[8] ? r.rd : r.rt;
  endfunction

  function automatic logic writes(input rec_t r, input logic [2:0] x);
    return r.v && r.ctrl[1] && recDest(r) != 3'd0 && recDest(r) == x;
  endfunction

  function automatic logic modelLs();
    rec_t e;
    e = pipe[0];
    return e.v && e.ctrl[3] && e.ctrl[1] && recDest(e) != 3'd0 &&
           (recDest(e) == bus.ID_Rs || recDest(e) == bus.ID_Rt);
  endfunction

  function automatic logic [1:0] fsel(input logic [2:0] x);
`ifdef ID_EX_FWD_PRECOMPUTE_EN
    if (writes(pipe[0], x)) return 2'b10;
    if (writes(pipe[1], x)) return 2'b01;
`endif
    return 2'b00;
  endfunction

  task automatic modelReset();
    pipe.delete();
    pipe.push_back('0);
    pipe.push_back('0);
  endtask

  task automatic modelEdge(input logic ls, input logic fl, input logic st,
                           input logic rs_);
    rec_t n;
    n.ctrl = bus.ID_Ctrl;
    n.rs   = bus.ID_Rs;
    n.rt   = bus.ID_Rt;
    n.rd   = bus.ID_Rd;
    n.d1   = bus.ID_ReadData1;
    n.d2   = bus.ID_ReadData2;
    n.imm  = bus.ID_Imm;
    n.v    = 1'b1;
    n.fa   = fsel(bus.ID_Rs);
    n.fb   = fsel(bus.ID_Rt);
    if (rs_) begin
      modelReset();
    end else if (fl || ls) begin
      n.v    = 1'b0;
      n.ctrl = '0;
      n.fa   = 2'b00;
      n.fb   = 2'b00;
      pipe.push_front(n);
      void'(pipe.pop_back());
    end else if (!st) begin
      pipe.push_front(n);
      void'(pipe.pop_back());
    end
  endtask

  task automatic chkOut();
    rec_t e;
    e = pipe[0];
    chk("EX_Ctrl", 32'(bus.EX_Ctrl), 32'(e.ctrl));
    chk("EX_Rs", 32'(bus.EX_Rs), 32'(e.rs));
    chk("EX_Rt", 32'(bus.EX_Rt), 32'(e.rt));
    chk("EX_Rd", 32'(bus.EX_Rd), 32'(e.rd));
    chk("EX_ReadData1", 32'(bus.EX_ReadData1), 32'(e.d1));
    chk("EX_ReadData2", 32'(bus.EX_ReadData2), 32'(e.d2));
    chk("EX_Imm", 32'(bus.EX_Imm), 32'(e.imm));
    chk("EX_Valid", 32'(bus.EX_Valid), 32'(e.v));
    chk("EX_ForwardA", 32'(bus.EX_ForwardA), 32'(e.fa));
    chk("EX_ForwardB", 32'(bus.EX_ForwardB), 32'(e.fb));
  endtask

  task automatic cycle();
    logic ls;
    #1;
    ls = rst ? 1'b0 : modelLs();
    if (!rst) chk("LoadStall", 32'(bus.LoadStall), 32'(ls));
    @(posedge clk);
    modelEdge(ls, bus.Flush, bus.Stall, rst);
    #1;
    chkOut();
  endtask

  task automatic setId(input logic [8:0] c, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [2:0] rd,
                       input logic [15:0] d1);
    bus.ID_Ctrl      = c;
    bus.ID_Rs        = rs;
    bus.ID_Rt        = rt;
    bus.ID_Rd        = rd;
    bus.ID_ReadData1 = d1;
    bus.ID_ReadData2 = d1 ^ 16'h5A5A;
    bus.ID_Imm       = ~d1;
  endtask

  initial begin
    modelReset();
    rst = 1'b1;
    bus.Stall = 1'b0;
    bus.Flush = 1'b0;
    setId(C_ADD, 3'd1, 3'd2, 3'd3, 16'hABCD);
    cycle();
    cycle();
    chk("reset_LoadStall", 32'(bus.LoadStall), 32'd0);
    rst = 1'b0;

    setId(C_WR, 3'd1, 3'd2, 3'd0, 16'h1111);
    cycle();
    chk("cap_ReadData1", 32'(bus.EX_ReadData1), 32'h1111);
    chk("cap_Valid", 32'(bus.EX_Valid), 32'd1);

    setId(C_LOAD, 3'd1, 3'd3, 3'd0, 16'h0040);
    cycle();
    setId(C_ADD, 3'd3, 3'd4, 3'd5, 16'h0007);
    #1;
    chk("lu_LoadStall", 32'(bus.LoadStall), 32'd1);
    cycle();
    chk("lu_bubble_Valid", 32'(bus.EX_Valid), 32'd0);
    #1;
    chk("lu_LoadStall_once", 32'(bus.LoadStall), 32'd0);
    cycle();
`ifdef ID_EX_FWD_PRECOMPUTE_EN
    chk("lu_ForwardA", 32'(bus.EX_ForwardA), 32'd1);
`endif

    setId(C_ADD, 3'd1, 3'd1, 3'd2, 16'h0100);
    cycle();
    setId(C_ADD, 3'd1, 3'd2, 3'd6, 16'h0200);
    cycle();
`ifdef ID_EX_FWD_PRECOMPUTE_EN
    chk("b2b_ForwardB", 32'(bus.EX_ForwardB), 32'd2);
`endif
    setId(C_ADD, 3'd1, 3'd1, 3'd2, 16'h0300);
    cycle();
    setId(9'h000, 3'd0, 3'd0, 3'd0, 16'h0000);
    cycle();
    setId(C_ADD, 3'd1, 3'd2, 3'd6, 16'h0400);
    cycle();
`ifdef ID_EX_FWD_PRECOMPUTE_EN
    chk("gap_ForwardB", 32'(bus.EX_ForwardB), 32'd1);
`endif
    setId(C_ADD, 3'd1, 3'd1, 3'd0, 16'h0500);
    cycle();
    setId(C_ADD, 3'd0, 3'd0, 3'd6, 16'h0600);
    cycle();
    chk("r0_ForwardB", 32'(bus.EX_ForwardB), 32'd0);

    setId(C_ADD, 3'd1, 3'd2, 3'd3, 16'h0700);
    bus.Flush = 1'b1;
    bus.Stall = 1'b1;
    cycle();
    chk("flush_Ctrl", 32'(bus.EX_Ctrl), 32'd0);
    chk("flush_Valid", 32'(bus.EX_Valid), 32'd0);
    bus.Flush = 1'b0;
    bus.Stall = 1'b0;

    setId(C_ADD, 3'd4, 3'd5, 3'd4, 16'h0800);
    cycle();
    setId(C_ADD, 3'd4, 3'd4, 3'd7, 16'h0900);
    cycle();
    bus.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      setId(C_ADD, 3'd7, 3'd1, 3'd2, 16'(16'hA000 + i));
      cycle();
    end
    chk("stall_ReadData1", 32'(bus.EX_ReadData1), 32'h0900);
    rst = 1'b1;
    cycle();
    chk("rst_stall_Valid", 32'(bus.EX_Valid), 32'd0);
    chk("rst_stall_Ctrl", 32'(bus.EX_Ctrl), 32'd0);
    rst = 1'b0;
    bus.Stall = 1'b0;

    for (int i = 0; i < 600; i++) begin
      logic [8:0] c;
      c = 9'($urandom);
      if ($urandom_range(0, 2) == 0) c = c | C_LOAD;
      setId(c, 3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
      bus.Flush = ($urandom_range(0, 9) == 0);
      bus.Stall = ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have one clock, clk; reset rst is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 Stall  input  1  hold all registered state this cycle.
REQ-005 Flush  input  1  insert bubble (branch/jump squash).
REQ-006 ID_Ctrl  input  9  {RegDst,ALUSrc,ALUOp[2:0],MemRead,MemWrite,RegWrite,MemToReg}.
REQ-007 ID_Rs  input  3  source register A.
REQ-008 ID_Rt  input  3  source register B / I-type destination.
REQ-009 ID_Rd  input  3  R-type destination.
REQ-010 ID_ReadData1  input  16  register-file read port A.
REQ-011 ID_ReadData2  input  16  register-file read port B.
REQ-012 ID_Imm  input  16  sign-extended immediate.
REQ-013 EX_Ctrl  output  9  registered ID_Ctrl.
REQ-014 EX_Rs  output  3  registered ID_Rs.
REQ-015 EX_Rt  output  3  registered ID_Rt.
REQ-016 EX_Rd  output  3  registered ID_Rd.
REQ-017 EX_ReadData1  output  16  registered ID_ReadData1.
REQ-018 EX_ReadData2  output  16  registered ID_ReadData2.
REQ-019 EX_Imm  output  16  registered ID_Imm.
REQ-020 EX_Valid  output  1  EX slot holds a real instruction.
REQ-021 LoadStall  output  1  combinational load-use hazard; upstream holds PC and IF/ID.
REQ-022 EX_ForwardA  output  2  registered operand-A select: 00 regfile, 10 Mem_ALUOut, 01 WB_WriteData.
REQ-023 EX_ForwardB  output  2  registered operand-B select, same encoding.

Function
REQ-024 Latency SHALL be one cycle: ID inputs appear on EX outputs after the next clk edge.
REQ-025 Edge priority SHALL be rst > Flush > LoadStall > Stall > capture.
REQ-026 Bubble (Flush or LoadStall) SHALL load EX_Ctrl=0, EX_Valid=0, EX_Forward*=00; data/register fields capture ID values.
REQ-027 Stall (no Flush/LoadStall) SHALL hold every register, including MEM/WB shadow state.
REQ-028 LoadStall SHALL be 1 iff EX_Valid & MemRead & RegWrite in EX_Ctrl & EX dest != 0 & EX dest equals ID_Rs or ID_Rt; EX dest = RegDst ? EX_Rd : EX_Rt.
REQ-029 LoadStall SHALL be 1 for exactly one cycle per load-use pair (bubble removes the match).
REQ-030 Shadow registers SHALL track dest, RegWrite, valid of instructions one (P1) and two (P2) stages ahead; advance on capture or bubble, hold on Stall.
REQ-031 Forward select for operand X (Rs for A, Rt for B) SHALL be 10 if P1 writes nonzero dest == X, else 01 if P2 writes nonzero dest == X, else 00; P1 wins ties.
REQ-032 Register 0 SHALL never match for hazard or forwarding.

Reset
REQ-033 On rst SHALL clear all outputs, shadow state and EX_Valid to 0; LoadStall reads 0 after reset.
REQ-034 rst mid-Stall or mid-LoadStall SHALL discard the pending instruction; first edge after rst deassertion captures normally.

Configuration
REQ-035 With ID_EX_FWD_PRECOMPUTE_EN defined SHALL compute EX_ForwardA/B per REQ-031.
REQ-036 Without it EX_ForwardA/B SHALL be tied 00, shadow registers omitted; an external forwarding unit uses EX_Rs/EX_Rt.

Structure
REQ-037 Package pipeline_pkg SHALL hold DATA_W=16, REG_W=3, CTRL_W=9, ID_Ctrl bit indices, FWD_REG/FWD_MEM/FWD_WB constants.
REQ-038 One sub-module id_ex_hazard SHALL hold LoadStall and forward-select logic; id_ex_stage holds registers.

Verification
REQ-039 Capture: ID_Rs=1,ID_Rt=2,ID_ReadData1=1111,ID_Ctrl RegWrite -> next edge EX_ReadData1=1111, EX_Valid=1, forwards 00.
REQ-040 Load-use: EX load to r3 (RegDst=0,Rt=3), ID_Rs=3 -> LoadStall=1 one cycle, bubble, then EX_ForwardA=01.
REQ-041 Back-to-back ALU: add r2 then use r2 as Rt -> EX_ForwardB=10; one-instruction gap -> 01; r0 dest -> 00.
REQ-042 Flush with Stall both high -> bubble wins, EX_Ctrl=0, EX_Valid=0.
REQ-043 Stall held 3 cycles -> all EX outputs and forwards unchanged; rst during Stall -> all zero next edge.
